// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-period helper, word framing tags and FSM state types.
// The transmit side uses the same framing tags.
package uart_pkg;

  localparam logic [1:0] HI_TAG = 2'b10;
  localparam logic [1:0] LO_TAG = 2'b00;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} byte_state_t;
  typedef enum logic {W_HI, W_LO} word_state_t;

  // Received byte viewed as a framing tag plus 6 sample bits
  typedef struct packed {
    logic [1:0] tag;
    logic [5:0] payload;
  } frame_byte_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchroniser on the serial pin followed by the byte FSM.
// Emits a one-cycle byte strobe, or a frame error when the stop bit is sampled low.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rxd,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic       o_busy_c
);

  localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    r_sync;
  logic          r_rxs_prev;
  byte_state_t   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [7:0]    r_byte, w_byte_nxt;
  logic          r_byte_valid, w_byte_valid_nxt;
  logic          r_frame_err, w_frame_err_nxt;
  logic          w_rxs;

  assign w_rxs        = r_sync[1];
  assign o_byte       = r_byte;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;
  assign o_busy_c     = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync       <= 2'b11;
      r_rxs_prev   <= 1'b1;
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_sync       <= {r_sync[0], i_rxd};
      r_rxs_prev   <= w_rxs;
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bit        <= w_bit_nxt;
      r_shift      <= w_shift_nxt;
      r_byte       <= w_byte_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_frame_err  <= w_frame_err_nxt;
    end
  end

  // Sampling points: start bit at its middle, then every full bit period from there
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_bit_nxt        = r_bit;
    w_shift_nxt      = r_shift;
    w_byte_nxt       = r_byte;
    w_byte_valid_nxt = 1'b0;
    w_frame_err_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_rxs_prev && !w_rxs) begin
          w_state_nxt = START;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
        end
      end
      START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rxs ? IDLE : DATA;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rxs, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nxt = STOP;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
          if (w_rxs) begin
            w_byte_valid_nxt = 1'b1;
            w_byte_nxt       = r_shift;
          end else begin
            w_frame_err_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_rx_word.sv
// Radiometer sample receiver: reassembles 12-bit samples from tagged high/low UART bytes,
// flagging sequence violations and inter-byte timeouts.
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rxd,
  output logic [11:0] data,
  output logic        valid,
  output logic        frame_err,
  output logic        sync_err,
  output logic        busy
);

  localparam int unsigned CPB      = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CPB;
  localparam int unsigned TW       = $clog2(TO_LIMIT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TO_LIMIT);

  frame_byte_t   w_rx;
  logic          w_byte_valid;
  logic          w_frame_err;
  logic          w_byte_busy_c;

  word_state_t   r_word, w_word_nxt;
  logic [5:0]    r_hi, w_hi_nxt;
  logic [11:0]   r_data, w_data_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_sync_err, w_sync_err_nxt;
  logic [TW-1:0] r_to, w_to_nxt;
  logic          r_busy, w_busy_nxt;

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB)
  ) u_rx_byte (
    .clk         (clk),
    .rst_n       (reset),
    .i_rxd       (uart_rxd),
    .o_byte      (w_rx),
    .o_byte_valid(w_byte_valid),
    .o_frame_err (w_frame_err),
    .o_busy_c    (w_byte_busy_c)
  );

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = w_frame_err;
  assign sync_err  = r_sync_err;
  assign busy      = r_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word     <= W_HI;
      r_hi       <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_sync_err <= 1'b0;
      r_to       <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_word     <= w_word_nxt;
      r_hi       <= w_hi_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_sync_err <= w_sync_err_nxt;
      r_to       <= w_to_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Word assembly; a frame error inside a word silently abandons it
  always_comb begin
    w_word_nxt     = r_word;
    w_hi_nxt       = r_hi;
    w_data_nxt     = r_data;
    w_valid_nxt    = 1'b0;
    w_sync_err_nxt = 1'b0;
    w_to_nxt       = r_to;
    case (r_word)
      W_HI: begin
        w_to_nxt = '0;
        if (w_byte_valid) begin
          if (w_rx.tag == HI_TAG) begin
            w_hi_nxt   = w_rx.payload;
            w_word_nxt = W_LO;
          end else begin
            w_sync_err_nxt = 1'b1;
          end
        end
      end
      W_LO: begin
        if (w_frame_err) begin
          w_word_nxt = W_HI;
          w_to_nxt   = '0;
        end else if (w_byte_valid) begin
          w_to_nxt = '0;
          if (w_rx.tag == HI_TAG) begin
            w_sync_err_nxt = 1'b1;
            w_hi_nxt       = w_rx.payload;
          end else if (w_rx.tag == LO_TAG) begin
            w_data_nxt  = {r_hi, w_rx.payload};
            w_valid_nxt = 1'b1;
            w_word_nxt  = W_HI;
          end else begin
            w_sync_err_nxt = 1'b1;
            w_word_nxt     = W_HI;
          end
        end else if (r_to == TO_MAX) begin
          w_sync_err_nxt = 1'b1;
          w_word_nxt     = W_HI;
          w_to_nxt       = '0;
        end else begin
          w_to_nxt = r_to + TW'(1);
        end
      end
      default: w_word_nxt = W_HI;
    endcase
    w_busy_nxt = w_byte_busy_c || (w_word_nxt == W_LO);
  end

endmodule

// File: tb/tb_uart_rx_word.sv
// Bench for uart_rx_word: byte table with an expected-strobe scoreboard, plus timeout,
// glitch and mid-word reset sequences.
module tb_uart_rx_word;
  import uart_pkg::*;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned TO_BITS  = 32;
  localparam int unsigned CPB      = CLK_FREQ / BAUD;

  typedef enum int {K_NONE, K_VALID, K_SYNC, K_FRAME} kind_t;
  typedef struct {
    kind_t       kind;
    logic [11:0] data;
  } exp_t;
  typedef struct {
    logic [7:0]  b;
    logic        stop;
    kind_t       kind;
    logic [11:0] data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic [11:0] data;
  logic        valid, frame_err, sync_err, busy;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned last_sync_cyc = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  kind_t       mon_kind;
  vec_t        vecs[18];

  uart_rx_word #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .TIMEOUT_BITS(TO_BITS)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .uart_rxd (rxd),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .sync_err (sync_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  // Scoreboard: every output strobe must match the oldest expected event
  always @(negedge clk) begin
    if (valid || sync_err || frame_err) begin
      mon_kind = valid ? K_VALID : (sync_err ? K_SYNC : K_FRAME);
      if (sync_err) last_sync_cyc = cyc;
      check("valid_sync_exclusive", 32'(valid & sync_err), 32'd0);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe actual_kind=%0d data=%h expected=none", mon_kind, data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.kind != mon_kind || (mon_kind == K_VALID && data !== mon_e.data)) begin
          errors++;
          $display("FAIL strobe actual_kind=%0d data=%h expected_kind=%0d data=%h",
                   mon_kind, data, mon_e.kind, mon_e.data);
        end
      end
    end
  end

  task automatic expect_ev(input kind_t k, input logic [11:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic bit_time(input logic v);
    rxd = v;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
    rxd = 1'b1;
    repeat (2 * CPB) @(posedge clk);
  endtask

  initial begin
    int unsigned t0;
    int unsigned n;
    logic        seen;
    logic [7:0]  partial;

    vecs[0]  = '{8'hAA, 1'b1, K_NONE,  12'h000};
    vecs[1]  = '{8'h3C, 1'b1, K_VALID, 12'hABC};
    vecs[2]  = '{8'h3C, 1'b1, K_SYNC,  12'h000};
    vecs[3]  = '{8'hAA, 1'b1, K_NONE,  12'h000};
    vecs[4]  = '{8'h3C, 1'b1, K_VALID, 12'hABC};
    vecs[5]  = '{8'hAA, 1'b0, K_FRAME, 12'h000};
    vecs[6]  = '{8'h81, 1'b1, K_NONE,  12'h000};
    vecs[7]  = '{8'h05, 1'b1, K_VALID, 12'h045};
    vecs[8]  = '{8'hC5, 1'b1, K_SYNC,  12'h000};
    vecs[9]  = '{8'h90, 1'b1, K_NONE,  12'h000};
    vecs[10] = '{8'h85, 1'b1, K_SYNC,  12'h000};
    vecs[11] = '{8'h2A, 1'b1, K_VALID, 12'h16A};
    vecs[12] = '{8'h9F, 1'b1, K_NONE,  12'h000};
    vecs[13] = '{8'h4F, 1'b1, K_SYNC,  12'h000};
    vecs[14] = '{8'h01, 1'b1, K_SYNC,  12'h000};
    vecs[15] = '{8'h81, 1'b1, K_NONE,  12'h000};
    vecs[16] = '{8'h05, 1'b0, K_FRAME, 12'h000};
    vecs[17] = '{8'h05, 1'b1, K_SYNC,  12'h000};

    repeat (4) @(posedge clk);
    #1;
    check("rst_data", 32'(data), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (2 * CPB) @(posedge clk);

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].kind != K_NONE) expect_ev(vecs[i].kind, vecs[i].data);
      send(vecs[i].b, vecs[i].stop);
      check($sformatf("row%0d_drained", i), 32'(exp_q.size()), 32'd0);
    end
    check("table_data_hold", 32'(data), 32'h16A);
    check("table_busy_idle", 32'(busy), 32'd0);

    // Inter-byte timeout followed by an orphan low byte
    expect_ev(K_SYNC, 12'h000);
    @(posedge clk);
    t0 = cyc;
    send(8'hAA, 1'b1);
    repeat (38 * CPB) @(posedge clk);
    checks++;
    if (exp_q.size() != 0 || last_sync_cyc - t0 < 660 || last_sync_cyc - t0 > 680) begin
      errors++;
      $display("FAIL timeout_timing actual_delta=%0d pending=%0d expected_delta=660..680",
               last_sync_cyc - t0, exp_q.size());
    end
    expect_ev(K_SYNC, 12'h000);
    send(8'h3C, 1'b1);
    check("orphan_drained", 32'(exp_q.size()), 32'd0);
    check("timeout_data_hold", 32'(data), 32'h16A);

    // Short low glitch on an idle line
    check("glitch_pre_busy", 32'(busy), 32'd0);
    rxd = 1'b0;
    repeat (5) @(posedge clk);
    rxd = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = busy;
    end
    check("glitch_busy_rise", 32'(seen), 32'd1);
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy || n > CPB / 2 + 3) begin
      errors++;
      $display("FAIL glitch_busy_fall actual_cycles=%0d busy=%0b expected<=%0d", n, busy, CPB / 2 + 3);
    end
    repeat (2 * CPB) @(posedge clk);

    // Reset in the middle of the low byte of a word
    send(8'hAA, 1'b1);
    partial = 8'h3C;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(partial[i]);
    repeat (CPB / 2) @(posedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_data", 32'(data), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    check("midrst_sync_err", 32'(sync_err), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    expect_ev(K_VALID, 12'hFFF);
    send(8'hBF, 1'b1);
    send(8'h3F, 1'b1);
    check("post_reset_drained", 32'(exp_q.size()), 32'd0);
    check("post_reset_data", 32'(data), 32'hFFF);
    check("post_reset_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
